// File: rtl/fifo_burst_arbiter_if.sv
// Burst requester bundle: request/length, per-beat write data, and per-burst completion.
// The requester drives the master side; the arbiter sits on the slave side.
interface fifo_burst_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
);
  logic             req;
  logic [LEN_W-1:0] len;
  logic             gnt;
  logic [WIDTH-1:0] wdata;
  logic             wvalid;
  logic             wlast;
  logic             wready;
  logic             done;
  logic             err;

  modport master (
    output req, len, wdata, wvalid, wlast,
    input  gnt, wready, done, err
  );

  modport slave (
    input  req, len, wdata, wvalid, wlast,
    output gnt, wready, done, err
  );
endinterface

// File: rtl/fifo_burst_arbiter.sv
// Shares one FIFO write port between two burst requesters, granting whole bursts
// round-robin, counting beats and reporting per-burst completion with error status.
module fifo_burst_arbiter #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  fifo_burst_arbiter_if.slave  s0,
  fifo_burst_arbiter_if.slave  s1,
  output logic                 fifo_wr_en,
  output logic [WIDTH-1:0]     fifo_wdata,
  input  logic                 fifo_full,
  output logic                 busy,
  output logic                 owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr;
  logic [LEN_W-1:0] beat_cnt;
  logic             err_flag;
  logic             gnt0;
  logic             gnt1;

  logic             any_req;
  logic             winner;
  logic [LEN_W-1:0] win_len;
  logic             own_wvalid;
  logic             own_wlast;
  logic [WIDTH-1:0] own_wdata;
  logic             own_wready;
  logic             beat_acc;
  logic             last_beat;

  // With both requesting, rr names the side that was not served last.
  assign any_req    = s0.req | s1.req;
  assign winner     = (s0.req & s1.req) ? rr : s1.req;
  assign win_len    = winner ? s1.len : s0.len;

  assign own_wvalid = owner ? s1.wvalid : s0.wvalid;
  assign own_wlast  = owner ? s1.wlast  : s0.wlast;
  assign own_wdata  = owner ? s1.wdata  : s0.wdata;
  assign own_wready = (state == XFER) & ~fifo_full;
  assign beat_acc   = own_wvalid & own_wready;
  assign last_beat  = (beat_cnt == '0) | own_wlast;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = XFER;
      XFER:    if (beat_acc && last_beat) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping: owner, beat down-counter, error accumulation, fairness pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner    <= 1'b0;
      rr       <= 1'b0;
      beat_cnt <= '0;
      err_flag <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= winner;
            beat_cnt <= win_len;
            err_flag <= 1'b0;
            gnt0     <= ~winner;
            gnt1     <= winner;
          end
        end
        XFER: begin
          if (beat_acc) begin
            if (beat_cnt == '0)  err_flag <= err_flag | ~own_wlast;
            else if (own_wlast)  err_flag <= 1'b1;
            else                 beat_cnt <= beat_cnt - LEN_W'(1);
          end
        end
        RESP: rr <= ~owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    s0.gnt     = gnt0;
    s1.gnt     = gnt1;
    s0.wready  = own_wready & ~owner;
    s1.wready  = own_wready & owner;
    fifo_wr_en = beat_acc;
    fifo_wdata = own_wdata;
    s0.done    = (state == RESP) & ~owner;
    s1.done    = (state == RESP) & owner;
    s0.err     = (state == RESP) & ~owner & err_flag;
    s1.err     = (state == RESP) & owner & err_flag;
    busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Directed bench for fifo_burst_arbiter: grants, beat streaming, stalls, error bursts,
// round-robin order and mid-burst reset, all against hand-computed expectations.
module tb_fifo_burst_arbiter;
  localparam int WIDTH = 32;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             fifo_full = 1'b0;
  logic             fifo_wr_en;
  logic [WIDTH-1:0] fifo_wdata;
  logic             busy;
  logic             owner;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int w0;

  fifo_burst_arbiter_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) s0_bus ();
  fifo_burst_arbiter_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) s1_bus ();

  fifo_burst_arbiter #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s0         (s0_bus),
    .s1         (s1_bus),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fifo_wr_en) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drv(input int who, input logic v, input logic [WIDTH-1:0] d, input logic l);
    if (who == 0) begin s0_bus.wvalid = v; s0_bus.wdata = d; s0_bus.wlast = l; end
    else          begin s1_bus.wvalid = v; s1_bus.wdata = d; s1_bus.wlast = l; end
  endtask

  task automatic set_req(input int who, input logic r, input logic [LEN_W-1:0] len);
    if (who == 0) begin s0_bus.req = r; s0_bus.len = len; end
    else          begin s1_bus.req = r; s1_bus.len = len; end
  endtask

  function automatic logic gnt_of(input int who);
    return (who == 0) ? s0_bus.gnt : s1_bus.gnt;
  endfunction
  function automatic logic wready_of(input int who);
    return (who == 0) ? s0_bus.wready : s1_bus.wready;
  endfunction
  function automatic logic done_of(input int who);
    return (who == 0) ? s0_bus.done : s1_bus.done;
  endfunction
  function automatic logic err_of(input int who);
    return (who == 0) ? s0_bus.err : s1_bus.err;
  endfunction

  // Request must already be set before the coming edge; gnt is expected exactly one cycle later.
  task automatic grant(input int who);
    @(negedge clk);
    set_req(who, 1'b0, '0);
    #1;
    chk("gnt", gnt_of(who), 1);
    chk("gnt_other", gnt_of(1 - who), 0);
    chk("owner", owner, who);
    chk("busy", busy, 1);
  endtask

  task automatic beats(input int who, input int n, input int wlast_at, input int stall_at,
                       input int stall_n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_n; k++) begin
          fifo_full = 1'b1;
          drv(who, 1'b1, base + i, i == wlast_at);
          #1;
          chk("stall_wready", wready_of(who), 0);
          chk("stall_wr_en", fifo_wr_en, 0);
          @(negedge clk);
        end
      end
      fifo_full = 1'b0;
      drv(who, 1'b1, base + i, i == wlast_at);
      #1;
      chk("wready", wready_of(who), 1);
      chk("wready_other", wready_of(1 - who), 0);
      chk("wr_en", fifo_wr_en, 1);
      chk("wdata", fifo_wdata, base + i);
      @(negedge clk);
    end
    drv(who, 1'b0, '0, 1'b0);
  endtask

  task automatic resp(input int who, input logic exp_err, input int exp_writes);
    #1;
    chk("done", done_of(who), 1);
    chk("err", err_of(who), exp_err);
    chk("done_other", done_of(1 - who), 0);
    chk("resp_wr_en", fifo_wr_en, 0);
    chk("resp_busy", busy, 1);
    chk("writes", wr_cnt - w0, exp_writes);
    @(negedge clk);
    #1;
    chk("done_clr", done_of(who), 0);
    chk("idle_busy", busy, 0);
    chk("owner_hold", owner, who);
  endtask

  initial begin
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    drv(0, 1'b0, '0, 1'b0);
    drv(1, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_owner", owner, 0);
    chk("rst_gnt", {s0_bus.gnt, s1_bus.gnt}, 0);
    chk("rst_wready", {s0_bus.wready, s1_bus.wready}, 0);
    chk("rst_done", {s0_bus.done, s1_bus.done, s0_bus.err, s1_bus.err}, 0);
    rstn = 1'b1;

    // Simultaneous requests, two rounds: s0, s1, s0, s1.
    for (int r = 0; r < 2; r++) begin
      set_req(0, 1'b1, 8'd1);
      set_req(1, 1'b1, 8'd1);
      w0 = wr_cnt;
      grant(0);
      beats(0, 2, 1, -1, 0, 32'h10 + 32'(r * 32));
      resp(0, 1'b0, 2);
      w0 = wr_cnt;
      grant(1);
      beats(1, 2, 1, -1, 0, 32'h20 + 32'(r * 32));
      resp(1, 1'b0, 2);
    end

    // Four-beat burst 0xA0..0xA3.
    set_req(0, 1'b1, 8'd3);
    w0 = wr_cnt;
    grant(0);
    beats(0, 4, 3, -1, 0, 32'hA0);
    resp(0, 1'b0, 4);

    // FIFO full for three cycles before the third beat.
    set_req(0, 1'b1, 8'd4);
    w0 = wr_cnt;
    grant(0);
    beats(0, 5, 4, 2, 3, 32'hB0);
    resp(0, 1'b0, 5);

    // Early wlast on beat 2 of a four-beat burst.
    set_req(1, 1'b1, 8'd3);
    w0 = wr_cnt;
    grant(1);
    beats(1, 2, 1, -1, 0, 32'hE0);
    resp(1, 1'b1, 2);

    // Maximum length: 256 beats without counter overflow.
    set_req(1, 1'b1, 8'hFF);
    w0 = wr_cnt;
    grant(1);
    beats(1, 256, 255, -1, 0, 32'h1000);
    resp(1, 1'b0, 256);

    // Single-beat bursts, missing wlast then proper wlast.
    set_req(0, 1'b1, 8'd0);
    w0 = wr_cnt;
    grant(0);
    beats(0, 1, -1, -1, 0, 32'h55);
    resp(0, 1'b1, 1);
    set_req(0, 1'b1, 8'd0);
    w0 = wr_cnt;
    grant(0);
    beats(0, 1, 0, -1, 0, 32'h66);
    resp(0, 1'b0, 1);

    // s0 served last, so s1 would be favoured; reset mid-burst must restore s0 priority.
    set_req(1, 1'b1, 8'd7);
    grant(1);
    beats(1, 1, -1, -1, 0, 32'hC0);
    drv(1, 1'b1, 32'hC1, 1'b0);
    #1;
    chk("pre_rst_wr_en", fifo_wr_en, 1);
    rstn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", fifo_wr_en, 0);
    chk("abort_owner", owner, 0);
    chk("abort_wready", {s0_bus.wready, s1_bus.wready}, 0);
    chk("abort_done", {s0_bus.done, s1_bus.done, s0_bus.err, s1_bus.err}, 0);
    drv(1, 1'b0, '0, 1'b0);
    set_req(1, 1'b1, 8'd1);
    set_req(0, 1'b1, 8'd0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("abort_hold_done", {s0_bus.done, s1_bus.done}, 0);
      chk("abort_hold_busy", busy, 0);
    end
    rstn = 1'b1;
    w0 = wr_cnt;
    grant(0);
    beats(0, 1, 0, -1, 0, 32'hD0);
    resp(0, 1'b0, 1);
    w0 = wr_cnt;
    grant(1);
    beats(1, 2, 1, -1, 0, 32'hF0);
    resp(1, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/fifo_burst_arbiter.md
Name: fifo_burst_arbiter

Overview:
Write-side arbiter that shares one sync_fifo write port between two burst sources, s0 and s1, for example two AXI5 write-data front ends.
- Grants whole bursts. Round-robin fairness applies at burst granularity.
- Counts beats against the granted length, checks the last-beat marker, and issues a per-burst completion with error status.
- Sits between the requesters and the FIFO's wr_en/wdata/fifo_full pins.

Parameters:
WIDTH, 32, data width of the requester and FIFO write data.
LEN_W, 8, width of the burst length field (beats = len+1).

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
s0_req  in  1  s0 requests a burst; held until s0_gnt
s0_len  in  LEN_W  s0 burst length minus 1; sampled with s0_req
s0_gnt  out  1  one-cycle pulse: burst accepted
s0_wdata  in  WIDTH  s0 write data
s0_wvalid  in  1  s0 beat valid
s0_wlast  in  1  s0 marks final beat
s0_wready  out  1  beat accepted when s0_wvalid & s0_wready
s0_done  out  1  one-cycle pulse: s0 burst finished
s0_err  out  1  burst error status, valid with s0_done
s1_*  (same set as s0_*, same widths)  requester 1
fifo_wr_en  out  1  FIFO write strobe
fifo_wdata  out  WIDTH  FIFO write data
fifo_full  in  1  FIFO full flag
busy  out  1  state != IDLE
owner  out  1  index of the current or last granted requester

Behaviour:
- Reset values (asynchronous on rstn low):
  - State IDLE; rr pointer prefers s0; owner=0; beat_cnt=0; err_flag=0.
  - All gnt/done/err/wready = 0; fifo_wr_en = 0; busy = 0.
- FSM has three states: IDLE, XFER, RESP.
- IDLE:
  - If any req is high, pick a winner on the next edge. With only one request, that requester wins. With both, the one not served last wins; after reset, s0 wins.
  - On that edge: owner <= winner; beat_cnt <= winner len; err_flag <= 0; sN_gnt <= 1 for one cycle; state <= XFER.
  - Latency: req high at edge k gives gnt high and wready eligible during cycle k+1.
- XFER:
  - s<owner>_wready = !fifo_full (combinational). The non-owner's wready = 0.
  - fifo_wr_en = owner wvalid & owner wready (combinational).
  - fifo_wdata = owner wdata, muxed combinationally; it is don't-care when fifo_wr_en=0.
  - Throughput is 1 beat per cycle while the FIFO is not full.
  - On each accepted beat:
    - If beat_cnt==0: this is the final beat. err_flag |= !wlast. State <= RESP.
    - Else if wlast=1: early termination. err_flag <= 1. State <= RESP.
    - Else: beat_cnt <= beat_cnt-1.
  - fifo_full high means no beat is accepted, the counter holds, and there is no timeout.
  - The non-owner's wvalid and req are ignored; its req stays pending.
- RESP (exactly one cycle):
  - s<owner>_done=1 and s<owner>_err=err_flag, both registered.
  - rr pointer <= !owner.
  - State <= IDLE.
  - A new grant can occur at the earliest one cycle after done, i.e. the next IDLE edge.
  - done/err for the non-owner stay 0.
- Boundaries:
  - len=0: single-beat burst; wlast is required on that beat.
  - len=2^LEN_W-1: full count with no overflow; beat_cnt is an unsigned LEN_W-bit down-counter.
  - A requester that drops req before gnt has undefined behaviour for that request; the block samples only at the arbitration edge.
  - Reset mid-burst aborts immediately and produces no done pulse. Beats already written remain in the FIFO; the FIFO's own reset governs them.
- busy = (state != IDLE).
- owner holds its value through IDLE until the next grant.

Test Plan:
- s0_req with s0_len=3, four beats 0xA0..0xA3, wlast on beat 4 -> s0_gnt one cycle after req; fifo_wr_en high 4 cycles with data 0xA0..0xA3; s0_done=1 and s0_err=0 one cycle after the 4th beat; busy falls next cycle.
- s0_req and s1_req asserted together after reset, each with len=1 -> s0 served first, then s1; owner goes 0 then 1. Repeat with both asserted -> s0 granted (rr pointer favours s0 after s1 was served last).
- fifo_full held high for 3 cycles mid-burst (len=4) -> s0_wready=0 and fifo_wr_en=0 for those 3 cycles; all 5 beats written in order; no err.
- s1 len=3 with wlast on beat 2 -> burst ends after 2 beats; s1_done=1 with s1_err=1; exactly 2 FIFO writes.
- s0 len=0 with wlast=0 -> 1 FIFO write; s0_done=1 with s0_err=1. Next burst len=0 with wlast=1 -> err=0.
- rstn low during beat 2 of a len=7 burst -> all outputs 0 immediately, no done pulse. After release, a pending s1_req and s0_req resolve to s0.
